mdu_ctrl: RTL

Multi-cycle multiply/divide unit controller for the pipelined MIPS core. It owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU over a fixed, parameterised number of cycles. It also sequences MTHI/MTLO and produces the stall request the hazard logic uses to hold MD-class instructions in decode while the unit is busy. It sits alongside the ALU in the execute stage; its HI/LO outputs feed MFHI/MFLO.

---
 rtl/mdu_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - HI/LO multiply/divide unit controller with fixed-latency busy window and decode stall
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        skip_q, skip_d;

    logic [63:0]        smul;
    logic [63:0]        umul;
    logic [31:0]        div_safe;
    logic               div_zero;
    logic               div_ovf;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic               md_start;

    assign smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign umul = {32'd0, a} * {32'd0, b};

    // A zero divisor is swapped for 1 so the dividers never see it; skip_q suppresses the commit.
    assign div_zero = (b == 32'd0);
    assign div_safe = div_zero ? 32'd1 : b;
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sq       = div_ovf ? 32'sh8000_0000 : ($signed(a) / $signed(div_safe));
    assign sr       = div_ovf ? 32'sd0 : ($signed(a) % $signed(div_safe));
    assign uq       = a / div_safe;
    assign ur       = a % div_safe;

    assign md_start = start && (op >= OP_MULT) && (op <= OP_DIVU);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        skip_d   = skip_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {res_hi_d, res_lo_d} = smul;
                            cnt_d   = MULT_LOAD;
                            skip_d  = 1'b0;
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            {res_hi_d, res_lo_d} = umul;
                            cnt_d   = MULT_LOAD;
                            skip_d  = 1'b0;
                            state_d = RUN;
                        end
                        OP_DIV: begin
                            res_hi_d = sr;
                            res_lo_d = sq;
                            cnt_d    = DIV_LOAD;
                            skip_d   = div_zero;
                            state_d  = RUN;
                        end
                        OP_DIVU: begin
                            res_hi_d = ur;
                            res_lo_d = uq;
                            cnt_d    = DIV_LOAD;
                            skip_d   = div_zero;
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    if (!skip_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            skip_q   <= skip_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = md_use_d && (busy || md_start);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
